arp_data_rx: RTL and testbench

ARP_DATA_RX -- requirements
Module: arp_data_rx

---
 rtl/arp_data_rx.sv | 157 +++++++++++++++
 tb/tb_arp_data_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_data_rx.sv
// ARP payload receiver: walks the 28-byte ARP body plus trailing padding,
// checks the fixed header fields and target IP, and reports done/error once per packet.
module arp_data_rx #(
    parameter int PAD_LEN = 18
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        eth_header_arp_done,
    input  logic        data_valid,
    input  logic [7:0]  data_in,
    input  logic [31:0] local_ip_addr,
    output logic        arp_oper,
    output logic [47:0] mac_s_addr,
    output logic [31:0] ip_s_addr,
    output logic [47:0] mac_d_addr,
    output logic [31:0] ip_d_addr,
    output logic        arp_data_done,
    output logic        arp_data_error
);

    typedef enum logic [3:0] {
        WAIT_START, HTYPE_RX, PTYPE_RX, HLEN_RX, PLEN_RX, OPER_RX,
        MAC_SOURCE_RX, IP_SOURCE_RX, MAC_DESTINATION_RX, IP_DESTINATION_RX, PADDING_RX
    } state_t;

    state_t      r_state, w_next_state;
    logic [4:0]  r_cnt;
    logic        r_err;
    logic [7:0]  r_prev_byte;
    logic        r_sh_oper;
    logic [47:0] r_sh_mac_s, r_sh_mac_d;
    logic [31:0] r_sh_ip_s, r_sh_ip_d;

    logic        w_consume, w_last, w_start, w_finish, w_mismatch, w_err_final;
    logic [15:0] w_word;
    logic [31:0] w_ip_d_now;

    function automatic int field_len(input state_t s);
        case (s)
            HTYPE_RX, PTYPE_RX, OPER_RX:       field_len = 2;
            HLEN_RX, PLEN_RX:                  field_len = 1;
            MAC_SOURCE_RX, MAC_DESTINATION_RX: field_len = 6;
            IP_SOURCE_RX, IP_DESTINATION_RX:   field_len = 4;
            PADDING_RX:                        field_len = PAD_LEN;
            default:                           field_len = 0;
        endcase
    endfunction

    function automatic state_t successor(input state_t s);
        case (s)
            HTYPE_RX:           successor = PTYPE_RX;
            PTYPE_RX:           successor = HLEN_RX;
            HLEN_RX:            successor = PLEN_RX;
            PLEN_RX:            successor = OPER_RX;
            OPER_RX:            successor = MAC_SOURCE_RX;
            MAC_SOURCE_RX:      successor = IP_SOURCE_RX;
            IP_SOURCE_RX:       successor = MAC_DESTINATION_RX;
            MAC_DESTINATION_RX: successor = IP_DESTINATION_RX;
            IP_DESTINATION_RX:  successor = (PAD_LEN == 0) ? WAIT_START : PADDING_RX;
            default:            successor = WAIT_START;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= WAIT_START;
        else          r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (r_state == WAIT_START) begin
            if (eth_header_arp_done) w_next_state = HTYPE_RX;
        end else if (w_last) begin
            w_next_state = successor(r_state);
        end
    end

    always_comb begin
        w_consume   = data_valid && (r_state != WAIT_START);
        w_last      = w_consume && (int'(r_cnt) == field_len(r_state) - 1);
        w_start     = (r_state == WAIT_START) && eth_header_arp_done;
        w_finish    = w_last && (successor(r_state) == WAIT_START);
        w_word      = {r_prev_byte, data_in};
        w_ip_d_now  = (r_state == IP_DESTINATION_RX) ? {r_sh_ip_d[23:0], data_in} : r_sh_ip_d;
        w_mismatch  = 1'b0;
        if (w_last) begin
            case (r_state)
                HTYPE_RX:          w_mismatch = (w_word != 16'h0001);
                PTYPE_RX:          w_mismatch = (w_word != 16'h0800);
                HLEN_RX:           w_mismatch = (data_in != 8'h06);
                PLEN_RX:           w_mismatch = (data_in != 8'h04);
                OPER_RX:           w_mismatch = (w_word != 16'h0001) && (w_word != 16'h0002);
                IP_DESTINATION_RX: w_mismatch = (w_ip_d_now != local_ip_addr);
                default:           w_mismatch = 1'b0;
            endcase
        end
        w_err_final = r_err | w_mismatch;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt          <= '0;
            r_err          <= 1'b0;
            r_prev_byte    <= '0;
            r_sh_oper      <= 1'b0;
            r_sh_mac_s     <= '0;
            r_sh_ip_s      <= '0;
            r_sh_mac_d     <= '0;
            r_sh_ip_d      <= '0;
            arp_oper       <= 1'b0;
            mac_s_addr     <= '0;
            ip_s_addr      <= '0;
            mac_d_addr     <= '0;
            ip_d_addr      <= '0;
            arp_data_done  <= 1'b0;
            arp_data_error <= 1'b0;
        end else begin
            if (w_start || w_last) r_cnt <= '0;
            else if (w_consume)    r_cnt <= r_cnt + 5'd1;

            if (w_start) begin
                r_err       <= 1'b0;
                r_prev_byte <= '0;
                r_sh_oper   <= 1'b0;
                r_sh_mac_s  <= '0;
                r_sh_ip_s   <= '0;
                r_sh_mac_d  <= '0;
                r_sh_ip_d   <= '0;
            end else if (w_consume) begin
                r_err       <= w_err_final;
                r_prev_byte <= data_in;
                case (r_state)
                    OPER_RX:            if (w_last) r_sh_oper <= (w_word == 16'h0001);
                    MAC_SOURCE_RX:      r_sh_mac_s <= {r_sh_mac_s[39:0], data_in};
                    IP_SOURCE_RX:       r_sh_ip_s  <= {r_sh_ip_s[23:0], data_in};
                    MAC_DESTINATION_RX: r_sh_mac_d <= {r_sh_mac_d[39:0], data_in};
                    IP_DESTINATION_RX:  r_sh_ip_d  <= w_ip_d_now;
                    default:            ;
                endcase
            end

            arp_data_done  <= w_finish && !w_err_final;
            arp_data_error <= w_finish && w_err_final;
            // Rejected packets leave the previous good packet visible on the outputs.
            if (w_finish && !w_err_final) begin
                arp_oper   <= r_sh_oper;
                mac_s_addr <= r_sh_mac_s;
                ip_s_addr  <= r_sh_ip_s;
                mac_d_addr <= r_sh_mac_d;
                ip_d_addr  <= w_ip_d_now;
            end
        end
    end

endmodule

// File: tb/tb_arp_data_rx.sv
// Randomised scoreboard bench for arp_data_rx: a field-level packet model predicts
// each done/error pulse, its cycle and the resulting outputs.
module tb_arp_data_rx;

    localparam int PAD = 18;
    localparam int PKT_BYTES = 28 + PAD;

    logic        aclk;
    logic        aresetn;
    logic        eth_header_arp_done;
    logic        data_valid;
    logic [7:0]  data_in;
    logic [31:0] local_ip_addr;
    logic        arp_oper;
    logic [47:0] mac_s_addr;
    logic [31:0] ip_s_addr;
    logic [47:0] mac_d_addr;
    logic [31:0] ip_d_addr;
    logic        arp_data_done;
    logic        arp_data_error;

    arp_data_rx #(.PAD_LEN(PAD)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .eth_header_arp_done (eth_header_arp_done),
        .data_valid          (data_valid),
        .data_in             (data_in),
        .local_ip_addr       (local_ip_addr),
        .arp_oper            (arp_oper),
        .mac_s_addr          (mac_s_addr),
        .ip_s_addr           (ip_s_addr),
        .mac_d_addr          (mac_d_addr),
        .ip_d_addr           (ip_d_addr),
        .arp_data_done       (arp_data_done),
        .arp_data_error      (arp_data_error)
    );

    typedef struct {
        bit          is_done;
        bit          oper;
        logic [47:0] mac_s;
        logic [31:0] ip_s;
        logic [47:0] mac_d;
        logic [31:0] ip_d;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pkt_q[$];
    int unsigned cycle_cnt;
    int          n_checks;
    int          n_pass;

    // Last accepted packet as seen by the model; rejected packets do not touch it.
    bit          hold_oper;
    logic [47:0] hold_mac_s, hold_mac_d;
    logic [31:0] hold_ip_s, hold_ip_d;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_bytes(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) pkt_q.push_back(v[i*8 +: 8]);
    endtask

    always @(negedge aclk) begin : monitor
        exp_t e;
        if (aresetn && (arp_data_done || arp_data_error)) begin
            check("done_and_error_exclusive", {arp_data_done, arp_data_error} == 2'b11, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {arp_data_done, arp_data_error}, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {arp_data_done, arp_data_error}, e.is_done ? 2'b10 : 2'b01);
                check("pulse_cycle", cycle_cnt, e.cyc);
                check("arp_oper", arp_oper, e.oper);
                check("mac_s_addr", mac_s_addr, e.mac_s);
                check("ip_s_addr", ip_s_addr, e.ip_s);
                check("mac_d_addr", mac_d_addr, e.mac_d);
                check("ip_d_addr", ip_d_addr, e.ip_d);
            end
        end
    end

    // mode: 0 = data_valid always high, 1 = toggling 1/0, 2 = random gaps.
    // limit < PKT_BYTES truncates the packet (used before a reset).
    task automatic send_pkt(input logic [15:0] htype, input logic [15:0] ptype,
                            input logic [7:0] hlen, input logic [7:0] plen,
                            input logic [15:0] oper, input logic [47:0] smac,
                            input logic [31:0] sip, input logic [47:0] tmac,
                            input logic [31:0] tip, input int mode,
                            input bit inj_dv, input bit mid_pulse, input int limit);
        exp_t e;
        bit   good;
        bit   phase;
        bit   dv;
        int   idx;
        pkt_q.delete();
        push_bytes(64'(htype), 2);
        push_bytes(64'(ptype), 2);
        push_bytes(64'(hlen), 1);
        push_bytes(64'(plen), 1);
        push_bytes(64'(oper), 2);
        push_bytes(64'(smac), 6);
        push_bytes(64'(sip), 4);
        push_bytes(64'(tmac), 6);
        push_bytes(64'(tip), 4);
        for (int i = 0; i < PAD; i++) pkt_q.push_back(8'($urandom));

        good = (htype == 16'h0001) && (ptype == 16'h0800) && (hlen == 8'h06) &&
               (plen == 8'h04) && ((oper == 16'h0001) || (oper == 16'h0002)) &&
               (tip == local_ip_addr);
        if (limit >= PKT_BYTES && good) begin
            hold_oper  = (oper == 16'h0001);
            hold_mac_s = smac;
            hold_ip_s  = sip;
            hold_mac_d = tmac;
            hold_ip_d  = tip;
        end
        e.is_done = good;
        e.oper    = hold_oper;
        e.mac_s   = hold_mac_s;
        e.ip_s    = hold_ip_s;
        e.mac_d   = hold_mac_d;
        e.ip_d    = hold_ip_d;

        eth_header_arp_done = 1'b1;
        data_valid          = inj_dv;
        data_in             = 8'hA5;
        tick();
        eth_header_arp_done = 1'b0;

        idx   = 0;
        phase = 1'b1;
        while (idx < limit && idx < PKT_BYTES) begin
            case (mode)
                0:       dv = 1'b1;
                1:       dv = phase;
                default: dv = ($urandom_range(0, 9) < 7);
            endcase
            phase               = ~phase;
            data_valid          = dv;
            data_in             = dv ? pkt_q[idx] : 8'($urandom);
            eth_header_arp_done = mid_pulse && (idx == 10 || idx == 30);
            if (dv && idx == PKT_BYTES - 1) begin
                e.cyc = cycle_cnt + 1;
                exp_q.push_back(e);
            end
            tick();
            if (dv) idx++;
        end
        data_valid          = 1'b0;
        eth_header_arp_done = 1'b0;
        repeat (2) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_oper"}, arp_oper, 0);
        check({tag, "_mac_s"}, mac_s_addr, 0);
        check({tag, "_ip_s"}, ip_s_addr, 0);
        check({tag, "_mac_d"}, mac_d_addr, 0);
        check({tag, "_ip_d"}, ip_d_addr, 0);
        check({tag, "_pulses"}, {arp_data_done, arp_data_error}, 0);
    endtask

    initial begin
        logic [15:0] r_htype, r_ptype, r_oper;
        logic [7:0]  r_hlen, r_plen;
        logic [31:0] r_tip;

        n_checks            = 0;
        n_pass              = 0;
        cycle_cnt           = 0;
        hold_oper           = 1'b0;
        hold_mac_s          = '0;
        hold_ip_s           = '0;
        hold_mac_d          = '0;
        hold_ip_d           = '0;
        aresetn             = 1'b0;
        eth_header_arp_done = 1'b0;
        data_valid          = 1'b0;
        data_in             = '0;
        local_ip_addr       = 32'hC0A80114;
        repeat (3) tick();
        check_outputs_zero("reset");
        aresetn = 1'b1;
        repeat (2) tick();

        // Valid request, constant data_valid, with a byte offered on the start cycle.
        send_pkt(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h020000000001,
                 32'hC0A8010A, 48'h0, 32'hC0A80114, 0, 1'b1, 1'b0, PKT_BYTES);
        // Valid reply, toggling data_valid.
        send_pkt(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002, 48'h0A1B2C3D4E5F,
                 32'hC0A80133, 48'h112233445566, 32'hC0A80114, 1, 1'b0, 1'b0, PKT_BYTES);
        // Wrong PTYPE: error, outputs hold the reply above.
        send_pkt(16'h0001, 16'h86DD, 8'h06, 8'h04, 16'h0001, 48'hDEADBEEF0001,
                 32'h01020304, 48'h0, 32'hC0A80114, 0, 1'b0, 1'b0, PKT_BYTES);
        // Target IP off by one.
        send_pkt(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'hDEADBEEF0002,
                 32'h05060708, 48'h0, 32'hC0A80115, 0, 1'b0, 1'b0, PKT_BYTES);
        // Reset after byte 20, then a full valid packet.
        send_pkt(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'hAAAAAAAAAAAA,
                 32'h0A0A0A0A, 48'h0, 32'hC0A80114, 0, 1'b0, 1'b0, 20);
        aresetn = 1'b0;
        tick();
        check_outputs_zero("midreset");
        hold_oper  = 1'b0;
        hold_mac_s = '0;
        hold_ip_s  = '0;
        hold_mac_d = '0;
        hold_ip_d  = '0;
        aresetn = 1'b1;
        repeat (2) tick();
        send_pkt(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h020000000001,
                 32'hC0A8010A, 48'h0, 32'hC0A80114, 0, 1'b0, 1'b0, PKT_BYTES);
        // Start pulses mid-packet are ignored.
        send_pkt(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002, 48'h665544332211,
                 32'hC0A80177, 48'hFFEEDDCCBBAA, 32'hC0A80114, 2, 1'b0, 1'b1, PKT_BYTES);

        for (int n = 0; n < 40; n++) begin
            r_htype = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h0001;
            r_ptype = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h0800;
            r_hlen  = ($urandom_range(0, 9) == 0) ? 8'($urandom)  : 8'h06;
            r_plen  = ($urandom_range(0, 9) == 0) ? 8'($urandom)  : 8'h04;
            case ($urandom_range(0, 5))
                0:       r_oper = 16'($urandom);
                1, 2:    r_oper = 16'h0001;
                default: r_oper = 16'h0002;
            endcase
            r_tip = ($urandom_range(0, 4) == 0) ? (local_ip_addr ^ (32'h1 << $urandom_range(0, 31)))
                                                : local_ip_addr;
            send_pkt(r_htype, r_ptype, r_hlen, r_plen, r_oper, {$urandom, $urandom},
                     $urandom, {$urandom, $urandom}, r_tip, int'($urandom_range(0, 2)),
                     1'($urandom), 1'($urandom_range(0, 3) == 0), PKT_BYTES);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
